// File: rtl/sixteen_by_eight_seq_divider_pkg.sv
// Shared arithmetic-datapath definitions for the sequential divider: FSM state
// encodings and the default operand width.
package sixteen_by_eight_seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sixteen_by_eight_seq_divider_if.sv
// Operand/result handshake bundle for the divider. The master supplies operands
// and consumes results; the slave is the divider.
interface sixteen_by_eight_seq_divider_if
    import sixteen_by_eight_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/sixteen_by_eight_seq_divider_div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and emit the quotient bit.
module div_restore_step
    import sixteen_by_eight_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   pr,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   pr_next_c,
    output logic             quotient_bit_c
);

    logic [WIDTH:0] pr_shift;
    logic [WIDTH:0] divisor_ext;

    // A restored remainder is always below the divisor, so its top bit is zero
    // and is dropped by the shift.
    logic unused_pr_msb;
    assign unused_pr_msb = pr[WIDTH];

    always_comb begin
        pr_shift       = {pr[WIDTH-1:0], dividend_bit};
        divisor_ext    = {1'b0, divisor};
        pr_next_c      = pr_shift;
        quotient_bit_c = 1'b0;
        if (pr_shift >= divisor_ext) begin
            pr_next_c      = pr_shift - divisor_ext;
            quotient_bit_c = 1'b1;
        end
    end

endmodule

// File: rtl/sixteen_by_eight_seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend over WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshakes on operands and result.
module sixteen_by_eight_seq_divider
    import sixteen_by_eight_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic                          clk,
    input logic                          rst_n,
    sixteen_by_eight_seq_divider_if.slave bus
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(DW);

    state_t           state_q, state_d;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH:0]   step_pr_c;
    logic             step_qbit_c;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .pr             (pr_q),
        .dividend_bit   (dvd_q[DW-1]),
        .divisor        (dvs_q),
        .pr_next_c      (step_pr_c),
        .quotient_bit_c (step_qbit_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        pr_d        = pr_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend[WIDTH-1:0];
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                        dvd_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        pr_d    = '0;
                        quo_d   = '0;
                        cnt_d   = CNT_W'(DW - 1);
                    end
                end
            end

            CALC: begin
                pr_d  = step_pr_c;
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                quo_d = {quo_q[DW-2:0], step_qbit_c};
                cnt_d = cnt_q - CNT_W'(1);
                // Final step: publish the result alongside the last quotient bit
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = {quo_q[DW-2:0], step_qbit_c};
                    remainder_d = step_pr_c[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            quo_q       <= '0;
            pr_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            pr_q        <= pr_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
